uart_cmd_framer: RTL and testbench
==================================

# uart_cmd_framer

Command-frame controller that sits between `uart_rx` and the RFID reader's command decoder. It paces `uart_rx` by consuming each received byte and pulsing its `receive` input. It hunts for a start-of-frame byte, assembles length-prefixed, XOR-checksummed command frames into a local payload buffer, and presents each good frame to the decoder through a valid/ready handshake. Malformed frames are dropped and reported on a one-cycle error strobe.

## Interface
Parameters:
- `DATA_BITS`, 8 — byte width; must match `uart_rx`.
- `MAX_LEN`, 16 — maximum payload bytes per frame (≥1).
- `SOF`, 8'hA5 — start-of-frame byte.
- `TIMEOUT_CYCLES`, 12000 — inter-byte timeout in `clk` cycles (1 ms at 12 MHz).

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `rx_valid`  in  1  — `uart_rx.valid`.
- `rx_byte`  in  DATA_BITS  — `uart_rx.rx_byte`.
- `rx_ack`  out  1  — to `uart_rx.receive`; one-cycle release pulse.
- `cmd_valid`  out  1  — complete, checked frame held in buffer.
- `cmd_ready`  in  1  — decoder done with frame.
- `cmd_len`  out  $clog2(MAX_LEN+1)  — payload length of held frame.
- `rd_addr`  in  $clog2(MAX_LEN)  — payload read index.
- `rd_data`  out  DATA_BITS  — combinational buffer read at `rd_addr`.
- `err_pulse`  out  1  — one-cycle frame-error strobe.
- `err_code`  out  2  — 1 = bad length, 2 = bad checksum, 3 = timeout; holds last value.

## Operation
- Frame format: `SOF`, `LEN`, `LEN` payload bytes, `CSUM`. `CSUM` = XOR of `LEN` and all payload bytes.
- Byte accept: `rx_valid && !rx_ack && state != HOLD`. Each accept registers `rx_ack`=1 for exactly one cycle. The `!rx_ack` term blocks double-consumption while `uart_rx` is still leaving DONE.
- States:
  - IDLE: accept any byte. If it equals `SOF`, go to LEN; otherwise discard it with no error.
  - LEN: store the byte in `cmd_len` and the checksum accumulator. 0 or >MAX_LEN → err 1, go to IDLE. Otherwise go to PAYLOAD with index 0.
  - PAYLOAD: write the byte to `buf[index]`, XOR it into the accumulator, and increment index. When index reaches `LEN`, go to CSUM.
  - CSUM: byte == accumulator → HOLD. Otherwise → err 2, go to IDLE.
  - HOLD: `cmd_valid`=1; no bytes accepted, so `uart_rx` holds its byte. `cmd_ready` sampled high → IDLE.
- Buffer contents and `cmd_len` are stable throughout HOLD.
- `cmd_ready` outside HOLD is ignored.
- Reset mid-frame: immediate return to IDLE and partial frame discarded; buffer RAM is not reset.

## Timing
- Reset values: `rx_ack`=0, `cmd_valid`=0, `cmd_len`=0, `err_pulse`=0, `err_code`=0, state IDLE.
- `rx_ack` is high in the cycle after the accepting edge.
- `cmd_valid` rises in the cycle after the CSUM byte is accepted. It falls in the cycle after the `cmd_ready` handshake edge. The first byte can be accepted in the following cycle.
- `err_pulse` and `err_code` are registered and appear in the cycle after the offending byte is accepted or the timeout expires.
- Accumulator and index widths: DATA_BITS and $clog2(MAX_LEN+1); the index never wraps because `LEN` ≤ `MAX_LEN`.
- Timeout and byte acceptance in the same cycle: the byte wins and the counter restarts.

## Configuration
- `UART_CMD_FRAMER_TIMEOUT_EN` defined:
  - A counter runs in LEN, PAYLOAD and CSUM and clears on each accept.
  - On reaching `TIMEOUT_CYCLES`, the block asserts err 3 and goes to IDLE.
  - The counter is held at 0 in IDLE and HOLD.
- Undefined: no counter is instantiated, a stalled frame waits indefinitely, and `err_code` 3 never occurs.

## Test plan
- Bytes A5 03 11 22 33 03 → `cmd_valid`=1, `cmd_len`=3; `rd_data` at addresses 0..2 = 11, 22, 33; six `rx_ack` pulses.
- Bytes A5 02 10 20 FF (correct CSUM is 32) → `err_pulse` with `err_code`=2, `cmd_valid` stays 0, state returns to IDLE.
- Bytes A5 00, then A5 followed by a LEN byte of MAX_LEN+1 (8'h11 at the default) → two error pulses with `err_code`=1; the following valid frame is accepted.
- Bytes 00 FF 5A before a valid frame → each is acked and discarded with no error; the frame is then delivered correctly.
- Valid frame with `cmd_ready` held low for 100 cycles while `rx_valid`=1 → `rx_ack` stays 0. One cycle of `cmd_ready` → `cmd_valid` falls, and `rx_ack` pulses in the following cycle.
- With `UART_CMD_FRAMER_TIMEOUT_EN`: A5 02 10 then silence → `err_code`=3 exactly `TIMEOUT_CYCLES`+1 cycles after the last accept. Without the macro: no error, and the frame completes after arbitrary delay.

Source files
------------

// File: rtl/uart_cmd_framer.sv
// Command-frame controller: SOF / LEN / payload / XOR checksum framing in front of the RFID command decoder.
// Optional inter-byte timeout is built when UART_CMD_FRAMER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module uart_cmd_framer #(
    parameter int                   DATA_BITS      = 8,
    parameter int                   MAX_LEN        = 16,
    parameter logic [DATA_BITS-1:0] SOF            = 8'hA5,
    parameter int                   TIMEOUT_CYCLES = 12000,
    localparam int                  LW             = $clog2(MAX_LEN + 1),
    localparam int                  AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_ack,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [LW-1:0]        cmd_len,
    input  logic [AW-1:0]        rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 err_pulse,
    output logic [1:0]           err_code
);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_HOLD} state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] acc;
    logic [LW-1:0]        idx;
    logic [LW-1:0]        idx_inc;
    logic [DATA_BITS-1:0] mem [MAX_LEN];
    logic                 accept;
    logic                 len_bad;
    logic                 timeout;
    logic                 err_set;
    logic [1:0]           err_val;
    logic                 wr_en;

    // !rx_ack keeps the byte uart_rx is still presenting from being taken twice
    assign accept  = rx_valid && !rx_ack && (state != S_HOLD);
    assign len_bad = (rx_byte == '0) || (rx_byte > DATA_BITS'(MAX_LEN));
    assign idx_inc = idx + 1'b1;
    assign rd_data = mem[rd_addr];

`ifdef UART_CMD_FRAMER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          in_frame;

    assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    // an accept in the expiry cycle wins and restarts the count
    assign timeout  = in_frame && !accept && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if (!in_frame || accept || timeout)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept && rx_byte == SOF) state_nxt = S_LEN;
            S_LEN:     if (accept) state_nxt = len_bad ? S_IDLE : S_PAYLOAD;
            S_PAYLOAD: if (accept && idx_inc == cmd_len) state_nxt = S_CSUM;
            S_CSUM:    if (accept) state_nxt = (rx_byte == acc) ? S_HOLD : S_IDLE;
            S_HOLD:    if (cmd_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (timeout)
            state_nxt = S_IDLE;
    end

    always_comb begin
        cmd_valid = (state == S_HOLD);
        wr_en     = accept && (state == S_PAYLOAD);
        err_set   = 1'b0;
        err_val   = err_code;
        if (accept && state == S_LEN && len_bad) begin
            err_set = 1'b1;
            err_val = 2'd1;
        end
        if (accept && state == S_CSUM && rx_byte != acc) begin
            err_set = 1'b1;
            err_val = 2'd2;
        end
        if (timeout) begin
            err_set = 1'b1;
            err_val = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ack    <= 1'b0;
            err_pulse <= 1'b0;
            err_code  <= 2'd0;
            cmd_len   <= '0;
            acc       <= '0;
            idx       <= '0;
        end else begin
            rx_ack    <= accept;
            err_pulse <= err_set;
            err_code  <= err_val;
            if (accept && state == S_LEN) begin
                cmd_len <= LW'(rx_byte);
                acc     <= rx_byte;
                idx     <= '0;
            end
            if (wr_en) begin
                acc <= acc ^ rx_byte;
                idx <= idx_inc;
            end
        end
    end

    // payload RAM is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[idx[AW-1:0]] <= rx_byte;
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Randomized scoreboard bench for uart_cmd_framer: frame-level generator predicts outcomes, a monitor checks them.
`timescale 1ns/1ps
module tb_uart_cmd_framer;
    localparam int DB = 8;
    localparam int ML = 16;
    localparam int TO = 40;
    localparam int LW = $clog2(ML + 1);
    localparam int AW = $clog2(ML);

    logic          clk, rst_n, rx_valid, rx_ack, cmd_valid, cmd_ready, err_pulse;
    logic [DB-1:0] rx_byte, rd_data;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] rd_addr;
    logic [1:0]    err_code;

    uart_cmd_framer #(.DATA_BITS(DB), .MAX_LEN(ML), .SOF(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ack(rx_ack),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .rd_addr(rd_addr),
        .rd_data(rd_data), .err_pulse(err_pulse), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        int         code;
        int         len;
        logic [7:0] pl [ML];
    } exp_t;

    exp_t expq[$];
    int   vectors = 0, miscompares = 0;
    int   cyc = 0, acks = 0, sent = 0, last_ack_cyc = 0;
    bit   first_frame = 1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rx_ack) begin
        acks         <= acks + 1;
        last_ack_cyc <= cyc;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // behaves like uart_rx: holds valid through the ack cycle, then drops it
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_byte  = b;
        rx_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_ack && n < 2000);
        if (!rx_ack) check("ack_wait_expired", 0, 1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        sent++;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push_good(input int len, input logic [7:0] pl [ML]);
        exp_t e;
        e.is_err = 0; e.code = 0; e.len = len; e.pl = pl;
        expq.push_back(e);
    endtask

    task automatic push_err(input int code);
        exp_t e;
        e.is_err = 1; e.code = code; e.len = 0;
        for (int i = 0; i < ML; i++) e.pl[i] = 8'h00;
        expq.push_back(e);
    endtask

    task automatic send_payload_frame(input int len, input logic [7:0] pl [ML], input logic [7:0] csum);
        send_byte(8'hA5);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) send_byte(pl[i]);
        send_byte(csum);
    endtask

    // kind: 0 good, 1 bad length, 2 bad checksum, 3 junk then good
    task automatic random_frame(input int kind);
        logic [7:0] pl [ML];
        logic [7:0] cs;
        int         len;
        len = $urandom_range(1, ML);
        cs  = 8'(len);
        for (int i = 0; i < ML; i++) pl[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < len; i++) cs = cs ^ pl[i];
        case (kind)
            1: begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(ML + 1, 255);
                push_err(1);
                send_byte(8'hA5);
                send_byte(8'(len));
            end
            2: begin
                push_err(2);
                send_payload_frame(len, pl, cs ^ 8'($urandom_range(1, 255)));
            end
            3: begin
                repeat ($urandom_range(1, 4)) begin
                    logic [7:0] j;
                    j = 8'($urandom_range(0, 255));
                    if (j == 8'hA5) j = 8'h5A;
                    send_byte(j);
                end
                push_good(len, pl);
                send_payload_frame(len, pl, cs);
            end
            default: begin
                push_good(len, pl);
                send_payload_frame(len, pl, cs);
            end
        endcase
    endtask

    // monitor: pops one expectation per err_pulse or per delivered frame
    initial begin
        exp_t e;
        int   h, n;
        cmd_ready = 1'b0;
        rd_addr   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (err_pulse) begin
                if (expq.size() == 0) check("unexpected_err", int'(err_code), -1);
                else begin
                    e = expq.pop_front();
                    check("err_expected", 1, int'(e.is_err));
                    check("err_code", int'(err_code), e.code);
`ifdef UART_CMD_FRAMER_TIMEOUT_EN
                    if (e.code == 3) check("timeout_latency", cyc - last_ack_cyc, TO);
`endif
                end
            end else if (cmd_valid) begin
                if (expq.size() == 0) begin
                    check("unexpected_frame", int'(cmd_len), -1);
                    e.is_err = 1; e.len = 0;
                end else e = expq.pop_front();
                check("frame_expected", 0, int'(e.is_err));
                check("cmd_len", int'(cmd_len), e.len);
                h = first_frame ? 100 : $urandom_range(1, 4);
                first_frame = 0;
                n = (h > e.len) ? h : e.len;
                for (int i = 0; i < n; i++) begin
                    if (i > 0) begin
                        @(negedge clk);
                        check("hold_no_ack", int'(rx_ack), 0);
                        check("hold_valid", int'(cmd_valid), 1);
                    end
                    if (i < e.len) begin
                        rd_addr = AW'(i);
                        #1;
                        check("rd_data", int'(rd_data), int'(e.pl[i]));
                    end
                end
                cmd_ready = 1'b1;
                @(negedge clk);
                cmd_ready = 1'b0;
                check("valid_fall", int'(cmd_valid), 0);
            end
        end
    end

    initial begin
        logic [7:0] pl [ML];
        int a0, n;
        rst_n = 1'b0; rx_valid = 1'b0; rx_byte = '0;
        for (int i = 0; i < ML; i++) pl[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ack", int'(rx_ack), 0);
        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_cmd_len", int'(cmd_len), 0);
        check("rst_err_pulse", int'(err_pulse), 0);
        check("rst_err_code", int'(err_code), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // A5 03 11 22 33 03, held 100 cycles by the monitor
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        a0 = acks;
        push_good(3, pl);
        send_payload_frame(3, pl, 8'h03);
        check("six_acks", acks - a0, 6);

        // A5 02 10 20 FF: checksum should be 32
        pl[0] = 8'h10; pl[1] = 8'h20;
        push_err(2);
        send_payload_frame(2, pl, 8'hFF);

        // zero length, then MAX_LEN+1
        push_err(1); send_byte(8'hA5); send_byte(8'h00);
        push_err(1); send_byte(8'hA5); send_byte(8'(ML + 1));
        pl[0] = 8'hC3;
        push_good(1, pl);
        send_payload_frame(1, pl, 8'h01 ^ 8'hC3);

        // junk before a frame is discarded silently
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        pl[0] = 8'h10; pl[1] = 8'h20;
        push_good(2, pl);
        send_payload_frame(2, pl, 8'h32);

        // stalled frame: A5 02 10, long silence, then 20 32
`ifdef UART_CMD_FRAMER_TIMEOUT_EN
        push_err(3);
`else
        push_good(2, pl);
`endif
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        repeat (3 * TO) @(posedge clk);
        #1;
        send_byte(8'h20); send_byte(8'h32);

        for (int k = 0; k < 30; k++) random_frame($urandom_range(0, 3));

        // reset in the middle of a frame
        n = 0;
        while (expq.size() != 0 && n < 5000) begin @(posedge clk); n++; end
        #1;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cmd_valid", int'(cmd_valid), 0);
        check("midrst_rx_ack", int'(rx_ack), 0);
        check("midrst_err_code", int'(err_code), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        random_frame(0);

        n = 0;
        while (expq.size() != 0 && n < 5000) begin @(posedge clk); n++; end
        repeat (5) @(posedge clk);
        check("scoreboard_drained", expq.size(), 0);
        check("ack_total", acks, sent);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
